// File: rtl/pl_pkg.sv
// ---------------------------------------------------------------------------
// pl_pkg -- shared definitions for the elastic pipeline stage registers.
//
// Contents:
//   pl_skid_state_e : occupancy state of a pl_skid_reg stage. The encoding
//                     doubles as the entry count (EMPTY=0, ONE=1, TWO=2).
//   PL_OCC_W        : width of the occupancy output.
//   PL_PERF_W       : native width of the performance counters.
//   pl_sat_inc()    : saturating increment used by the perf counters.
//
// Stage-specific payload packing structs belong in each stage's own
// package, not here.
// ---------------------------------------------------------------------------
package pl_pkg;

    typedef enum logic [1:0] {
        PL_EMPTY = 2'd0,
        PL_ONE   = 2'd1,
        PL_TWO   = 2'd2
    } pl_skid_state_e;

    localparam int PL_OCC_W  = 2;
    localparam int PL_PERF_W = 32;

    // Returns value+1 unless value already equals max_v, in which case the
    // value sticks. Operates on the widest counter; narrower counters pass
    // their own all-ones as max_v.
    function automatic logic [PL_PERF_W-1:0] pl_sat_inc(
        input logic [PL_PERF_W-1:0] value,
        input logic [PL_PERF_W-1:0] max_v
    );
        if (value >= max_v) begin
            return max_v;
        end
        return value + {{(PL_PERF_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/pl_sat_cnt.sv
// ---------------------------------------------------------------------------
// pl_sat_cnt -- parametrised saturating event counter.
//
// Parameters:
//   W      : counter width (1..32).
// Ports:
//   clk    : clock, rising edge.
//   rst    : synchronous active-high reset, clears the count.
//   inc_i  : count this cycle.
//   cnt_o  : current count; sticks at all-ones, never wraps.
// ---------------------------------------------------------------------------
module pl_sat_cnt
    import pl_pkg::*;
#(
    parameter int W = PL_PERF_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    localparam logic [PL_PERF_W-1:0] MAX_V =
        (W >= PL_PERF_W) ? {PL_PERF_W{1'b1}}
                         : ((PL_PERF_W'(1) << W) - PL_PERF_W'(1));

    logic [W-1:0]         cnt_q;
    logic [W-1:0]         cnt_d;
    logic [PL_PERF_W-1:0] cnt_wide;
    logic [PL_PERF_W-1:0] inc_wide;

    assign cnt_wide = PL_PERF_W'(cnt_q);
    assign inc_wide = pl_sat_inc(cnt_wide, MAX_V);

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i) begin
            cnt_d = inc_wide[W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pl_skid_reg.sv
// ---------------------------------------------------------------------------
// pl_skid_reg -- elastic pipeline stage register with a 2-entry skid buffer.
//
// Carries a PC plus an opaque payload between pipeline stages with a
// valid/ready handshake. in_ready comes straight from a flop, so there is
// no combinational path from out_ready back to in_ready. Pipeline-control
// stall (freeze) and flush (empty) keep their usual meaning.
//
// Parameters:
//   PC_W        : width of the carried word-address PC.
//   PAYLOAD_W   : width of the opaque payload bus.
//   RST_PAYLOAD : payload shown while the stage is empty (e.g. a NOP).
// Ports:
//   clk, rst              : clock; synchronous active-high reset.
//   stall                 : hold all state, mask both handshakes.
//   flush                 : drop everything held and the same-cycle input.
//   in_valid/in_ready     : upstream handshake (in_ready registered).
//   in_pc/in_payload      : upstream entry.
//   out_valid/out_ready   : downstream handshake.
//   out_pc/out_payload    : head entry (0 / RST_PAYLOAD when empty).
//   occupancy             : entries held, 0..2.
//   perf_bubble/perf_full : only with PL_SKID_PERF_EN defined. Saturating
//                           counts of starved cycles (downstream ready,
//                           nothing to give) and of cycles spent full.
//                           Cleared by rst only.
// ---------------------------------------------------------------------------
module pl_skid_reg
    import pl_pkg::*;
#(
    parameter int                   PC_W        = 30,
    parameter int                   PAYLOAD_W   = 64,
    parameter logic [PAYLOAD_W-1:0] RST_PAYLOAD = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PC_W-1:0]      in_pc,
    input  logic [PAYLOAD_W-1:0] in_payload,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PC_W-1:0]      out_pc,
    output logic [PAYLOAD_W-1:0] out_payload,
`ifdef PL_SKID_PERF_EN
    output logic [PL_PERF_W-1:0] perf_bubble,
    output logic [PL_PERF_W-1:0] perf_full,
`endif
    output logic [PL_OCC_W-1:0]  occupancy
);

    pl_skid_state_e       state_q, state_d;
    logic                 in_ready_q, in_ready_d;
    logic [PC_W-1:0]      main_pc_q, main_pc_d;
    logic [PAYLOAD_W-1:0] main_pl_q, main_pl_d;
    logic [PC_W-1:0]      skid_pc_q, skid_pc_d;
    logic [PAYLOAD_W-1:0] skid_pl_q, skid_pl_d;

    logic accept;
    logic emit;

    // Stall masks both handshakes so neither side sees a transfer while the
    // stage is frozen.
    assign in_ready  = in_ready_q & ~stall;
    assign out_valid = (state_q != PL_EMPTY) & ~stall;
    assign accept    = in_valid & in_ready;
    assign emit      = out_valid & out_ready;

    // The main register is returned to 0/RST_PAYLOAD whenever it empties,
    // so the outputs never show stale data.
    assign out_pc      = main_pc_q;
    assign out_payload = main_pl_q;
    assign occupancy   = PL_OCC_W'(state_q);

    always_comb begin
        state_d   = state_q;
        main_pc_d = main_pc_q;
        main_pl_d = main_pl_q;
        skid_pc_d = skid_pc_q;
        skid_pl_d = skid_pl_q;

        if (flush) begin
            state_d   = PL_EMPTY;
            main_pc_d = '0;
            main_pl_d = RST_PAYLOAD;
        end else if (!stall) begin
            unique case (state_q)
                PL_EMPTY: begin
                    if (accept) begin
                        state_d   = PL_ONE;
                        main_pc_d = in_pc;
                        main_pl_d = in_payload;
                    end
                end
                PL_ONE: begin
                    if (accept && emit) begin
                        main_pc_d = in_pc;
                        main_pl_d = in_payload;
                    end else if (accept) begin
                        // Downstream stalled: park the new entry behind main.
                        state_d   = PL_TWO;
                        skid_pc_d = in_pc;
                        skid_pl_d = in_payload;
                    end else if (emit) begin
                        state_d   = PL_EMPTY;
                        main_pc_d = '0;
                        main_pl_d = RST_PAYLOAD;
                    end
                end
                PL_TWO: begin
                    // in_ready is low here, so only the drain path exists.
                    if (emit) begin
                        state_d   = PL_ONE;
                        main_pc_d = skid_pc_q;
                        main_pl_d = skid_pl_q;
                    end
                end
                default: begin
                    state_d   = PL_EMPTY;
                    main_pc_d = '0;
                    main_pl_d = RST_PAYLOAD;
                end
            endcase
        end

        // Ready for next cycle is decided from the next state, which is what
        // lets in_ready be a plain flop.
        in_ready_d = (state_d != PL_TWO);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= PL_EMPTY;
            in_ready_q <= 1'b1;
            main_pc_q  <= '0;
            main_pl_q  <= RST_PAYLOAD;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            main_pc_q  <= main_pc_d;
            main_pl_q  <= main_pl_d;
        end
    end

    // Skid contents are only read in PL_TWO, which reset never leaves us in.
    always_ff @(posedge clk) begin
        skid_pc_q <= skid_pc_d;
        skid_pl_q <= skid_pl_d;
    end

`ifdef PL_SKID_PERF_EN
    logic [1:0]           perf_inc;
    logic [PL_PERF_W-1:0] perf_cnt [2];

    assign perf_inc[0] = out_ready & ~out_valid & ~stall;
    assign perf_inc[1] = (state_q == PL_TWO);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_perf
            pl_sat_cnt #(
                .W (PL_PERF_W)
            ) u_cnt (
                .clk   (clk),
                .rst   (rst),
                .inc_i (perf_inc[gi]),
                .cnt_o (perf_cnt[gi])
            );
        end
    endgenerate

    assign perf_bubble = perf_cnt[0];
    assign perf_full   = perf_cnt[1];
`endif

    a_occ_le_two : assert property (@(posedge clk) occupancy != 2'd3);

    a_head_stable : assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready && !stall && !flush)
            |=> ($stable(out_pc) && $stable(out_payload)));

endmodule

// File: tb/tb_pl_skid_reg.sv
// ---------------------------------------------------------------------------
// tb_pl_skid_reg -- self-checking bench for pl_skid_reg.
// Directed vector table (inputs applied, outputs checked before the edge
// that consumes them), a seeded random handshake run against a FIFO
// scoreboard, and perf-counter checks when PL_SKID_PERF_EN is defined.
// ---------------------------------------------------------------------------
module tb_pl_skid_reg;
    import pl_pkg::*;

    localparam int          PC_W      = 30;
    localparam int          PAYLOAD_W = 64;
    localparam logic [63:0] RSTP      = 64'h0000_0013_0000_0013;

    logic                 clk;
    logic                 rst;
    logic                 stall;
    logic                 flush;
    logic                 in_valid;
    logic                 in_ready;
    logic [PC_W-1:0]      in_pc;
    logic [PAYLOAD_W-1:0] in_payload;
    logic                 out_valid;
    logic                 out_ready;
    logic [PC_W-1:0]      out_pc;
    logic [PAYLOAD_W-1:0] out_payload;
    logic [1:0]           occupancy;
`ifdef PL_SKID_PERF_EN
    logic [31:0]          perf_bubble;
    logic [31:0]          perf_full;
`endif

    pl_skid_reg #(
        .PC_W        (PC_W),
        .PAYLOAD_W   (PAYLOAD_W),
        .RST_PAYLOAD (RSTP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_pc       (in_pc),
        .in_payload  (in_payload),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_payload (out_payload),
`ifdef PL_SKID_PERF_EN
        .perf_bubble (perf_bubble),
        .perf_full   (perf_full),
`endif
        .occupancy   (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Payload is a fixed function of the PC so the bench can predict it.
    function automatic logic [63:0] pl_of(input logic [PC_W-1:0] pc);
        return {32'hA5A5_0000 ^ {2'b00, pc}, ~{2'b00, pc}};
    endfunction

    typedef struct {
        bit              chk;
        bit              rst;
        bit              stall;
        bit              flush;
        bit              iv;
        logic [PC_W-1:0] pc;
        bit              ordy;
        bit              e_ov;
        logic [PC_W-1:0] e_pc;
        bit              e_ir;
        logic [1:0]      e_occ;
    } vec_t;

    vec_t vt[$];

    task automatic add(input bit chk, input bit r, input bit st, input bit fl,
                       input bit iv, input int pc, input bit ordy,
                       input bit e_ov, input int e_pc, input bit e_ir, input int e_occ);
        vec_t v;
        v.chk = chk; v.rst = r; v.stall = st; v.flush = fl; v.iv = iv;
        v.pc = PC_W'(pc); v.ordy = ordy; v.e_ov = e_ov; v.e_pc = PC_W'(e_pc);
        v.e_ir = e_ir; v.e_occ = 2'(e_occ);
        vt.push_back(v);
    endtask

    logic [PC_W-1:0] sb[$];

    // One random-run cycle: drive, check occupancy against the model, then
    // score any transfer that the coming edge will perform.
    task automatic rnd_cycle(input bit iv_r, input bit ordy_r, input bit stall_r, input bit hold_pc);
        logic [PC_W-1:0] exp_pc;
        @(posedge clk);
        #1;
        in_valid  = iv_r;
        out_ready = ordy_r;
        stall     = stall_r;
        if (!hold_pc) begin
            in_pc = PC_W'($urandom);
        end
        in_payload = pl_of(in_pc);
        #1;
        check("rnd_occupancy", 64'(occupancy), 64'(sb.size()));
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("rnd_spurious_emit", 64'(out_pc), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                exp_pc = sb.pop_front();
                check("rnd_out_pc", 64'(out_pc), 64'(exp_pc));
                check("rnd_out_payload", out_payload, pl_of(exp_pc));
            end
        end
        if (in_valid && in_ready) begin
            sb.push_back(in_pc);
        end
    endtask

    initial begin
        bit held;
        rst = 1'b1; stall = 1'b0; flush = 1'b0; in_valid = 1'b0;
        out_ready = 1'b0; in_pc = '0; in_payload = '0;

        //   chk rst st fl iv pc     ordy | ov  pc    ir occ
        // reset, then 4 back-to-back entries with downstream always ready
        add(0, 1, 0, 0, 0, 0,      0,     0, 0,     1, 0);
        add(1, 0, 0, 0, 0, 0,      1,     0, 0,     1, 0);
        add(1, 0, 0, 0, 1, 'h10,   1,     0, 0,     1, 0);
        add(1, 0, 0, 0, 1, 'h11,   1,     1, 'h10,  1, 1);
        add(1, 0, 0, 0, 1, 'h12,   1,     1, 'h11,  1, 1);
        add(1, 0, 0, 0, 1, 'h13,   1,     1, 'h12,  1, 1);
        add(1, 0, 0, 0, 0, 0,      1,     1, 'h13,  1, 1);
        add(1, 0, 0, 0, 0, 0,      0,     0, 0,     1, 0);
        // back-pressure fills the skid, then drains in order
        add(1, 0, 0, 0, 1, 'hA0,   0,     0, 0,     1, 0);
        add(1, 0, 0, 0, 1, 'hA1,   0,     1, 'hA0,  1, 1);
        add(1, 0, 0, 0, 1, 'hA2,   0,     1, 'hA0,  0, 2);
        add(1, 0, 0, 0, 1, 'hA2,   1,     1, 'hA0,  0, 2);
        add(1, 0, 0, 0, 1, 'hA2,   1,     1, 'hA1,  1, 1);
        add(1, 0, 0, 0, 0, 0,      1,     1, 'hA2,  1, 1);
        add(1, 0, 0, 0, 0, 0,      1,     0, 0,     1, 0);
        // flush while full drops everything including the same-cycle input
        add(1, 0, 0, 0, 1, 'hB0,   0,     0, 0,     1, 0);
        add(1, 0, 0, 0, 1, 'hB1,   0,     1, 'hB0,  1, 1);
        add(1, 0, 0, 1, 1, 'hB2,   0,     1, 'hB0,  0, 2);
        add(1, 0, 0, 0, 0, 0,      1,     0, 0,     1, 0);
        // three-cycle stall in ONE, then the held entry leaves first
        add(1, 0, 0, 0, 1, 'hC0,   1,     0, 0,     1, 0);
        add(1, 0, 1, 0, 1, 'hC1,   1,     0, 'hC0,  0, 1);
        add(1, 0, 1, 0, 1, 'hC1,   1,     0, 'hC0,  0, 1);
        add(1, 0, 1, 0, 1, 'hC1,   1,     0, 'hC0,  0, 1);
        add(1, 0, 0, 0, 1, 'hC1,   1,     1, 'hC0,  1, 1);
        add(1, 0, 0, 0, 0, 0,      1,     1, 'hC1,  1, 1);
        add(1, 0, 0, 0, 0, 0,      1,     0, 0,     1, 0);
        // reset while full
        add(1, 0, 0, 0, 1, 'hD0,   0,     0, 0,     1, 0);
        add(1, 0, 0, 0, 1, 'hD1,   0,     1, 'hD0,  1, 1);
        add(1, 1, 0, 0, 1, 'hD2,   0,     1, 'hD0,  0, 2);
        add(1, 0, 0, 0, 0, 0,      0,     0, 0,     1, 0);
        // flush wins over stall
        add(1, 0, 0, 0, 1, 'hE0,   0,     0, 0,     1, 0);
        add(1, 0, 1, 1, 1, 'hE1,   0,     0, 'hE0,  0, 1);
        add(1, 0, 0, 0, 0, 0,      0,     0, 0,     1, 0);

        foreach (vt[i]) begin
            @(posedge clk);
            #1;
            rst        = vt[i].rst;
            stall      = vt[i].stall;
            flush      = vt[i].flush;
            in_valid   = vt[i].iv;
            in_pc      = vt[i].pc;
            in_payload = pl_of(vt[i].pc);
            out_ready  = vt[i].ordy;
            #1;
            if (vt[i].chk) begin
                check($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(vt[i].e_ov));
                check($sformatf("vec%0d_out_pc", i), 64'(out_pc), 64'(vt[i].e_pc));
                check($sformatf("vec%0d_out_payload", i), out_payload,
                      (vt[i].e_occ == 2'd0) ? RSTP : pl_of(vt[i].e_pc));
                check($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'(vt[i].e_ir));
                check($sformatf("vec%0d_occupancy", i), 64'(occupancy), 64'(vt[i].e_occ));
            end
        end

        // Saturating increment helper shared with the perf counters.
        check("sat_inc_top", 64'(pl_sat_inc(32'hFFFF_FFFF, 32'hFFFF_FFFF)), 64'hFFFF_FFFF);
        check("sat_inc_mid", 64'(pl_sat_inc(32'd5, 32'hFFFF_FFFF)), 64'd6);
        check("sat_inc_narrow", 64'(pl_sat_inc(32'h0000_00FF, 32'h0000_00FF)), 64'hFF);

`ifdef PL_SKID_PERF_EN
        @(posedge clk); #1;
        rst = 1'b1; stall = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("perf_bubble_after_rst", 64'(perf_bubble), 64'd0);
        repeat (5) @(posedge clk);
        #1;
        check("perf_bubble_5_idle", 64'(perf_bubble), 64'd5);
        out_ready = 1'b0; in_valid = 1'b1; in_pc = 30'h55; in_payload = pl_of(30'h55);
        @(posedge clk); #1;
        in_pc = 30'h56; in_payload = pl_of(30'h56);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("perf_full_3", 64'(perf_full), 64'd3);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("perf_survives_flush", 64'(perf_bubble), 64'd5);
`endif

        // Random handshake run, then drain.
        @(posedge clk); #1;
        rst = 1'b1; stall = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        void'($urandom(1));
        held = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            // Keep a presented-but-unaccepted entry steady, like a real
            // upstream would.
            rnd_cycle(held ? 1'b1 : 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 3) != 0),
                      ($urandom_range(0, 15) == 0),
                      held);
            held = in_valid && !in_ready;
        end
        for (int c = 0; c < 4; c++) begin
            rnd_cycle(1'b0, 1'b1, 1'b0, 1'b0);
        end
        check("rnd_drained", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pl_skid_reg.md
Name: pl_skid_reg

Overview:
- Parametrised elastic pipeline stage register: replaces the fixed-field stall/flush stage registers between pipeline stages.
- Carries a PC plus an opaque payload bus of any width. Each stage packs its own fields into the payload.
- Adds a valid/ready handshake with a 2-entry skid buffer, so in_ready is fully registered (no combinational ready path).
- Keeps the pipeline-control stall/flush semantics.

Parameters:
- PC_W, 30, width of carried word-address PC.
- PAYLOAD_W, 64, width of opaque payload bus.
- RST_PAYLOAD, '0, payload value driven while stage empty/after reset/flush (e.g. NOP encodings).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- stall  in  1  pipeline-control hold: freezes stage.
- flush  in  1  pipeline-control flush: empties stage.
- in_valid  in  1  upstream has an entry.
- in_ready  out  1  stage can accept; registered.
- in_pc  in  PC_W  upstream PC.
- in_payload  in  PAYLOAD_W  upstream payload.
- out_valid  out  1  stage presents an entry.
- out_ready  in  1  downstream accepts.
- out_pc  out  PC_W  PC of head entry.
- out_payload  out  PAYLOAD_W  payload of head entry.
- occupancy  out  2  entries held (0..2).

Behaviour:
- Storage:
  - Main register (head, drives outputs) and skid register.
  - State enum: EMPTY (0 entries), ONE (main full), TWO (main+skid full).
- Reset (rst=1 at clk edge): state EMPTY; out_valid=0; out_pc=0; out_payload=RST_PAYLOAD; in_ready=1 from the next cycle; occupancy=0; skid contents don't-care.
- Transfer definitions:
  - accept = in_valid & in_ready & ~stall.
  - emit = out_valid & out_ready & ~stall.
  - While stall=1, in_ready and out_valid are forced 0 combinationally.
- Priority per edge: rst > flush > stall > normal.
- flush=1 (with or without stall): state EMPTY; out_pc=0; out_payload=RST_PAYLOAD; in_ready=1 next cycle. The same-cycle in_valid is dropped.
- stall=1, no flush: all state held.
- Transitions:
  - EMPTY: accept -> ONE, main<=in.
  - ONE:
    - accept & emit -> ONE, main<=in.
    - accept only -> TWO, skid<=in.
    - emit only -> EMPTY, main<=RST values.
  - TWO (in_ready=0, so no accept):
    - emit -> ONE, main<=skid.
- in_ready register = next state != TWO.
- Latency: 1 cycle from accept to out_valid when empty. Full throughput (1 entry/cycle) when downstream is never back-pressured.
- Ordering strictly FIFO. Skid never overtakes main.
- While out_valid=0, out_pc/out_payload are held at 0/RST_PAYLOAD, never stale data.
- Mid-operation reset: treated as flush plus in_ready reset. No partial entries survive.
- Assertions (sim only):
  - occupancy never 3.
  - out_pc/out_payload stable while out_valid & ~out_ready & ~stall & ~flush.

Optional Feature:
- Macro PL_SKID_PERF_EN.
- Defined:
  - Extra outputs perf_bubble (32-bit) and perf_full (32-bit).
  - perf_bubble increments on cycles with out_ready=1 & out_valid=0 & ~stall.
  - perf_full increments on cycles in state TWO.
  - Both saturate at all-ones and clear on rst only (not flush).
- Undefined: ports and counters absent; no other behavioural change.

Decomposition:
- Shared package pl_pkg:
  - typedef enum logic [1:0] pl_skid_state_e {PL_EMPTY, PL_ONE, PL_TWO}.
  - localparam PL_OCC_W=2.
  - Saturating-increment function used by the perf counters.
- Stage-specific payload packing structs live in each stage's package, not here.
- One natural sub-module: pl_sat_cnt (parametrised saturating counter), instantiated twice under PL_SKID_PERF_EN.

Test Plan:
- Reset then 4 back-to-back inputs (pc 0x10..0x13), out_ready=1 -> out_pc 0x10..0x13 on consecutive cycles starting 1 cycle later; occupancy stays 1; in_ready stays 1.
- out_ready=0, send pc 0xA0, 0xA1, 0xA2 -> occupancy 2 after 0xA1; in_ready=0 the cycle after; 0xA2 held upstream. Release out_ready -> outputs 0xA0, 0xA1, 0xA2 in order, no loss or duplication.
- State TWO plus flush=1 with in_valid=1 -> next cycle occupancy 0, out_valid=0, out_payload=RST_PAYLOAD, in_ready=1; flushed input not seen.
- stall=1 for 3 cycles in state ONE with out_ready=1, in_valid=1 -> in_ready=0, out_valid=0, state/outputs unchanged; release -> held entry emitted first.
- rst asserted in state TWO -> next edge all outputs at reset values.
- Random valid/ready (seed 1) for 10k cycles against a queue scoreboard -> exact in-order match.
- With PL_SKID_PERF_EN: 5 idle cycles with out_ready=1 -> perf_bubble=5; force counter near all-ones -> saturates, no wrap.
